// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing a two-channel SPI master among NREQ command sources.
// Define SPI_ARB_TIMEOUT_EN to abort stalled handshakes with an err pulse.
//   IDLE      | no transfer; arbitrate among eligible requesters
//   ISSUE     | request latched; fire spi_start on the chosen channel
//   WAIT_ACK  | wait for the channel's spi_ready to drop
//   WAIT_DONE | wait for the channel's spi_ready to return high
//   DONE      | req_done pulsing; arbitrates again like IDLE
module spi_arbiter #(
    parameter int NREQ         = 3,
    parameter int ACK_TIMEOUT  = 15,
    parameter int BUSY_TIMEOUT = 4095
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_chan,
    input  logic [NREQ-1:0]      req_dir,
    input  logic [NREQ*24-1:0]   req_data,
    input  logic [NREQ*8-1:0]    req_depth,
    output logic [NREQ-1:0]      req_accept,
    output logic [NREQ-1:0]      req_done,
    input  logic [1:0]           spi_ready,
    output logic [1:0]           spi_start,
    output logic                 spi_dir,
    output logic [23:0]          spi_data_tx,
    output logic [7:0]           spi_data_depth,
    output logic                 busy,
    output logic                 err
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || ACK_TIMEOUT < 1 || BUSY_TIMEOUT < 1) begin : g_param_check
        $error("spi_arbiter: parameter out of range");
    end

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, DONE} state_t;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   owner;
    logic            chan;
    logic [IW-1:0]   next_rr;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TMAX = (ACK_TIMEOUT > BUSY_TIMEOUT) ? ACK_TIMEOUT : BUSY_TIMEOUT;
    localparam int CW   = $clog2(TMAX + 1);
    logic [CW-1:0]   wait_cnt;
`endif

    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] elig_hi;
    logic            pick_ok;
    logic [IW-1:0]   pick_idx;
    logic            pick_chan;
    logic            pick_dir;
    logic [23:0]     pick_data;
    logic [7:0]      pick_depth;

    // Search from rr_ptr upward first, then wrap to the low indices.
    always_comb begin
        elig       = '0;
        elig_hi    = '0;
        pick_ok    = 1'b0;
        pick_idx   = '0;
        pick_chan  = 1'b0;
        pick_dir   = 1'b0;
        pick_data  = '0;
        pick_depth = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i]    = req_valid[i] & spi_ready[req_chan[i]];
            elig_hi[i] = elig[i] & (IW'(i) >= rr_ptr);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!pick_ok && elig_hi[i]) begin
                pick_ok  = 1'b1;
                pick_idx = IW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!pick_ok && elig[i]) begin
                pick_ok  = 1'b1;
                pick_idx = IW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (IW'(i) == pick_idx) begin
                pick_chan  = req_chan[i];
                pick_dir   = req_dir[i];
                pick_data  = req_data[i*24 +: 24];
                pick_depth = req_depth[i*8 +: 8];
            end
        end
    end

    assign next_rr = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            owner          <= '0;
            chan           <= 1'b0;
            req_accept     <= '0;
            req_done       <= '0;
            spi_start      <= '0;
            spi_dir        <= 1'b0;
            spi_data_tx    <= '0;
            spi_data_depth <= '0;
            busy           <= 1'b0;
            err            <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            wait_cnt       <= '0;
`endif
        end else begin
            req_accept <= '0;
            req_done   <= '0;
            spi_start  <= '0;
            err        <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (pick_ok) begin
                        req_accept     <= NREQ'(1) << pick_idx;
                        owner          <= pick_idx;
                        chan           <= pick_chan;
                        spi_dir        <= pick_dir;
                        spi_data_tx    <= pick_data;
                        spi_data_depth <= pick_depth;
                        busy           <= 1'b1;
                        state          <= ISSUE;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    spi_start[chan] <= 1'b1;
                    state           <= WAIT_ACK;
`ifdef SPI_ARB_TIMEOUT_EN
                    wait_cnt        <= '0;
`endif
                end
                WAIT_ACK: begin
                    if (!spi_ready[chan]) begin
                        state    <= WAIT_DONE;
`ifdef SPI_ARB_TIMEOUT_EN
                        wait_cnt <= '0;
                    end else if (wait_cnt >= CW'(ACK_TIMEOUT)) begin
                        err      <= 1'b1;
                        req_done <= NREQ'(1) << owner;
                        rr_ptr   <= next_rr;
                        state    <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                WAIT_DONE: begin
                    if (spi_ready[chan]) begin
                        req_done <= NREQ'(1) << owner;
                        rr_ptr   <= next_rr;
                        state    <= DONE;
`ifdef SPI_ARB_TIMEOUT_EN
                    end else if (wait_cnt >= CW'(BUSY_TIMEOUT)) begin
                        err      <= 1'b1;
                        req_done <= NREQ'(1) << owner;
                        rr_ptr   <= next_rr;
                        state    <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_spi_arbiter;
    localparam int NREQ = 3;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req_valid, req_chan, req_dir;
    logic [NREQ*24-1:0]   req_data;
    logic [NREQ*8-1:0]    req_depth;
    logic [NREQ-1:0]      req_accept, req_done;
    logic [1:0]           spi_ready, spi_start;
    logic                 spi_dir;
    logic [23:0]          spi_data_tx;
    logic [7:0]           spi_data_depth;
    logic                 busy, err;

    spi_arbiter #(.NREQ(NREQ), .ACK_TIMEOUT(15), .BUSY_TIMEOUT(4095)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_chan(req_chan), .req_dir(req_dir),
        .req_data(req_data), .req_depth(req_depth),
        .req_accept(req_accept), .req_done(req_done),
        .spi_ready(spi_ready), .spi_start(spi_start),
        .spi_dir(spi_dir), .spi_data_tx(spi_data_tx), .spi_data_depth(spi_data_depth),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk, n_pass, cyc;
    int acc_cyc, done_cyc, err_cyc, start_cyc, done_n, err_n;
    int e0, d0, dn0;
    logic [1:0] last_start;
    int grants[$];
    bit model_on, resp_en;
    int rmode, xfer_fix;
    int left[2];
    bit pend[2], hold[2];

    // reference model: one outstanding transaction, measured by its age in cycles
    int m_own, m_age, m_rr, m_chan;
    bit m_low, m_dn;
    logic m_dir;
    logic [23:0] m_data;
    logic [7:0] m_depth;
    logic [NREQ-1:0] e_acc, e_done;
    logic [1:0] e_start;
    logic e_busy;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_accept"}, req_accept, 0);
        chk({tag, "_done"}, req_done, 0);
        chk({tag, "_start"}, spi_start, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_dir"}, spi_dir, 0);
        chk({tag, "_data"}, spi_data_tx, 0);
        chk({tag, "_depth"}, spi_data_depth, 0);
    endtask

    task automatic model_clear();
        m_own = -1; m_age = 0; m_rr = 0; m_chan = 0; m_low = 0; m_dn = 0;
        m_dir = 1'b0; m_data = '0; m_depth = '0;
        e_acc = '0; e_done = '0; e_start = '0; e_busy = 1'b0;
    endtask

    task automatic model_step();
        int pick;
        e_acc = '0; e_done = '0; e_start = '0;
        if (!rst_n) begin
            model_clear();
            return;
        end
        if (m_own >= 0 && !m_dn) begin
            m_age++;
            if (m_age == 1) e_start[m_chan] = 1'b1;
            else if (!m_low) begin
                if (!spi_ready[m_chan]) m_low = 1;
            end else if (spi_ready[m_chan]) begin
                e_done[m_own] = 1'b1;
                m_dn = 1;
                m_rr = (m_own + 1) % NREQ;
            end
            e_busy = 1'b1;
        end else begin
            pick = -1;
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_rr + k) % NREQ;
                if (pick < 0 && req_valid[i] && spi_ready[req_chan[i]]) pick = i;
            end
            m_dn = 0;
            if (pick >= 0) begin
                m_own = pick; m_age = 0; m_low = 0;
                m_chan = int'(req_chan[pick]);
                m_dir = req_dir[pick];
                m_data = req_data[pick*24 +: 24];
                m_depth = req_depth[pick*8 +: 8];
                e_acc[pick] = 1'b1;
                e_busy = 1'b1;
            end else begin
                m_own = -1;
                e_busy = 1'b0;
            end
        end
    endtask

    task automatic set_req(input int i, input int c, input int d,
                           input logic [23:0] data, input logic [7:0] depth);
        req_chan[i] = c[0];
        req_dir[i] = d[0];
        req_data[i*24 +: 24] = data;
        req_depth[i*8 +: 8] = depth;
        req_valid[i] = 1'b1;
    endtask

    // Called at a falling edge: check this cycle, update stimulus, predict next cycle.
    task automatic step();
        if (model_on) begin
            chk("req_accept", req_accept, e_acc);
            chk("req_done", req_done, e_done);
            chk("spi_start", spi_start, e_start);
            chk("busy", busy, e_busy);
            chk("err", err, 0);
            chk("spi_dir", spi_dir, m_dir);
            chk("spi_data_tx", spi_data_tx, m_data);
            chk("spi_data_depth", spi_data_depth, m_depth);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (req_accept[i]) begin
                grants.push_back(i);
                acc_cyc = cyc;
                if (rmode != 0) req_valid[i] = 1'b0;
            end
        end
        if (req_done != '0) begin done_n++; done_cyc = cyc; end
        if (err) begin err_n++; err_cyc = cyc; end
        if (spi_start != '0) begin last_start = spi_start; start_cyc = cyc; end
        if (rmode == 2) begin
            for (int i = 0; i < NREQ; i++)
                if (!req_valid[i] && $urandom_range(3) == 0)
                    set_req(i, $urandom_range(1), $urandom_range(1), 24'($urandom),
                            ($urandom_range(3) == 0) ? 8'd0 : 8'($urandom_range(255)));
            for (int c = 0; c < 2; c++)
                if ($urandom_range(15) == 0) hold[c] = !hold[c];
        end
        for (int c = 0; c < 2; c++) begin
            if (left[c] > 0) left[c]--;
            if (pend[c]) begin
                left[c] = (rmode == 2) ? $urandom_range(12, 1) : xfer_fix;
                pend[c] = 0;
            end
            if (spi_start[c] && resp_en) pend[c] = 1;
            spi_ready[c] = (left[c] == 0) && !hold[c];
        end
        if (model_on) model_step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_until_done(input int target, input int budget);
        for (int k = 0; k < budget && done_n < target; k++) step();
        chk("done_within_budget", done_n, target);
    endtask

    task automatic run_until_idle(input int budget);
        for (int k = 0; k < budget && !(busy == 1'b0 && req_valid == '0); k++) step();
        chk("idle_within_budget", busy, 0);
    endtask

    initial begin
        n_chk = 0; n_pass = 0; cyc = 0;
        acc_cyc = -1; done_cyc = -1; err_cyc = -1; start_cyc = -1;
        done_n = 0; err_n = 0; last_start = '0;
        req_valid = '0; req_chan = '0; req_dir = '0; req_data = '0; req_depth = '0;
        spi_ready = 2'b11;
        for (int c = 0; c < 2; c++) begin left[c] = 0; pend[c] = 0; hold[c] = 0; end
        resp_en = 1; model_on = 1; rmode = 1; xfer_fix = 10;
        model_clear();

        repeat (2) @(negedge clk);
        chk_reset("por");
        rst_n = 1'b1;
        repeat (3) step();

        // round robin with all three requesting channel 0 continuously
        rmode = 0; xfer_fix = 2; grants.delete();
        set_req(0, 0, 0, 24'h111111, 8'd1);
        set_req(1, 0, 1, 24'h222222, 8'd2);
        set_req(2, 0, 0, 24'h333333, 8'd3);
        run_until_done(done_n + 6, 200);
        req_valid = '0;
        run_until_idle(100);
        for (int k = 0; k < 6; k++)
            chk("rr_order", (grants.size() > k) ? grants[k] : -1, k % 3);

        // single request on channel 1 with a 10-cycle transfer
        rmode = 1; xfer_fix = 10; grants.delete(); acc_cyc = -1;
        set_req(0, 1, 1, 24'hA5C3F0, 8'd3);
        run_until_done(done_n + 1, 60);
        chk("single_grant", (grants.size() > 0) ? grants[0] : -1, 0);
        chk("single_start", last_start, 2'b10);
        chk("single_start_lat", start_cyc - acc_cyc, 1);
        chk("single_done_lat", done_cyc - acc_cyc, 13);
        run_until_idle(20);

        // channel skip: move rr_ptr to 0, then hold channel 1 busy
        xfer_fix = 3;
        set_req(2, 0, 0, 24'h0000C4, 8'd0);
        run_until_done(done_n + 1, 40);
        run_until_idle(20);
        grants.delete();
        hold[1] = 1;
        set_req(0, 1, 0, 24'h5A5A5A, 8'd7);
        set_req(1, 0, 1, 24'h0F0F0F, 8'd0);
        run_until_done(done_n + 1, 40);
        repeat (3) step();
        chk("skip_wait", grants.size(), 1);
        hold[1] = 0;
        run_until_done(done_n + 1, 40);
        run_until_idle(20);
        chk("skip_first", (grants.size() > 0) ? grants[0] : -1, 1);
        chk("skip_second", (grants.size() > 1) ? grants[1] : -1, 0);

        // reset in WAIT_DONE with rr_ptr at 2 and two requests pending
        set_req(1, 0, 0, 24'h777777, 8'd2);
        run_until_done(done_n + 1, 40);
        run_until_idle(20);
        grants.delete(); xfer_fix = 10;
        set_req(1, 0, 1, 24'hBEEF01, 8'd9);
        for (int k = 0; k < 20 && grants.size() == 0; k++) step();
        chk("rst_pre_accept", grants.size(), 1);
        set_req(0, 0, 0, 24'h000A0A, 8'd4);
        set_req(2, 0, 0, 24'h000B0B, 8'd5);
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        chk_reset("rst_mid");
        model_clear();
        dn0 = done_n;
        repeat (2) step();
        chk("rst_no_done", done_n, dn0);
        rst_n = 1'b1;
        grants.delete();
        run_until_done(done_n + 1, 60);
        run_until_idle(80);
        chk("rst_rr_first", (grants.size() > 0) ? grants[0] : -1, 0);

        // spi_ready never drops after start
        model_on = 0; resp_en = 0;
        acc_cyc = -1; err_cyc = -1; done_cyc = -1;
        e0 = err_n; d0 = done_n;
        set_req(0, 0, 0, 24'hDEAD00, 8'd1);
        repeat (40) step();
        chk("to_accepted", acc_cyc >= 0, 1);
`ifdef SPI_ARB_TIMEOUT_EN
        chk("to_err_lat", err_cyc - acc_cyc, 17);
        chk("to_done_lat", done_cyc - acc_cyc, 17);
        chk("to_err_n", err_n - e0, 1);
        chk("to_busy_idle", busy, 0);
`else
        chk("to_err_n", err_n - e0, 0);
        chk("to_done_n", done_n - d0, 0);
        chk("to_busy_hung", busy, 1);
`endif
        rst_n = 1'b0;
        #1;
        model_clear();
        model_on = 1; resp_en = 1;
        step();
        rst_n = 1'b1;
        step();

        // randomized traffic
        rmode = 2;
        repeat (1500) step();
        rmode = 1;
        req_valid = '0;
        hold[0] = 0; hold[1] = 0;
        run_until_idle(200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
